reg_cmd_decoder: RTL

//  Host-side master for the config/status register file: accepts 16-bit command words

---
 rtl/reg_map_pkg.sv | 31 +++
 rtl/reg_cmd_decoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/reg_map_pkg.sv
// Register-map constants and types shared by the host command decoder.
package reg_map_pkg;

  localparam logic [3:0] ADDR_VERSN    = 4'h0;
  localparam logic [3:0] ADDR_HWRID    = 4'h1;
  localparam logic [3:0] ADDR_CTRL     = 4'h2;
  localparam logic [3:0] ADDR_MODE     = 4'h3;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'h4;
  localparam logic [3:0] ADDR_THRESH   = 4'h5;
  localparam logic [3:0] ADDR_PERIOD   = 4'h6;
  localparam logic [3:0] ADDR_SCRATCH0 = 4'h7;
  localparam logic [3:0] ADDR_SCRATCH1 = 4'h8;
  localparam logic [3:0] ADDR_STATS    = 4'h9;

  localparam logic [15:0] RSP_ERR_DATA = 16'h0000;

  typedef struct packed {
    logic        rw;
    logic [10:0] rsvd;
    logic [3:0]  addr;
  } cmd_word_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } dec_state_e;

endpackage

// File: rtl/reg_cmd_decoder.sv
// Host command decoder: turns read/write command words into register strobes
// and returns exactly one response word per command.
module reg_cmd_decoder
  import reg_map_pkg::*;
#(
  parameter int          NumRegs       = 10,
  parameter logic [15:0] WritableMask  = 16'h03FC,
  parameter logic [3:0]  StatsAddr     = ADDR_STATS,
  parameter int          TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [15:0]           cmd_data_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  output logic [15:0]           rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  input  logic [16*NumRegs-1:0] reg_rd_data_i,
  output logic [15:0]           reg_wr_data_o,
  output logic [NumRegs-1:0]    reg_we_o,
  output logic                  stats_read_o,
  output dec_state_e            dec_state
);

  localparam int CntW = $clog2(TimeoutCycles);

  // Handshakes: a word moves on cmd_valid_i && cmd_ready_o at posedge, a response
  // on rsp_valid_o && rsp_ready_i; valid never depends on ready and is held until taken.

  dec_state_e      state, state_next;
  cmd_word_t       cmd;
  logic            accept;
  logic            cmd_bad;
  logic            tmo_done;
  logic [CntW-1:0] tmo_cnt;
  logic [3:0]      addr_q;
  logic            wr_bad_q;
  logic [15:0]     wdata_q;
  logic [15:0]     rsp_data_q;
  logic            rsp_err_q;
  logic [15:0]     rd_word;

  assign cmd      = cmd_word_t'(cmd_data_i);
  assign accept   = cmd_valid_i && cmd_ready_o;
  assign tmo_done = (tmo_cnt == CntW'(TimeoutCycles - 1));

  always_comb begin
    cmd_bad = (cmd.rsvd != '0) || (32'(cmd.addr) >= NumRegs) ||
              (cmd.rw && !WritableMask[cmd.addr]);
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (addr_q == 4'(i)) rd_word = reg_rd_data_i[16*i +: 16];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmd.rw)       state_next = ST_WDATA;
          else if (cmd_bad) state_next = ST_RESP;
          else              state_next = ST_READ;
        end
      end
      ST_WDATA: begin
        if (accept)        state_next = wr_bad_q ? ST_RESP : ST_WRITE;
        else if (tmo_done) state_next = ST_RESP;
      end
      ST_WRITE: state_next = ST_RESP;
      ST_READ:  state_next = ST_RESP;
      ST_RESP:  if (rsp_ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // A rejected write still swallows its data word so the host stays framed.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tmo_cnt    <= '0;
      addr_q     <= '0;
      wr_bad_q   <= 1'b0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (accept) begin
            addr_q   <= cmd.addr;
            wr_bad_q <= cmd_bad;
            if (!cmd.rw && cmd_bad) begin
              rsp_data_q <= RSP_ERR_DATA;
              rsp_err_q  <= 1'b1;
            end
          end
        end
        ST_WDATA: begin
          if (accept) begin
            tmo_cnt <= '0;
            if (wr_bad_q) begin
              rsp_data_q <= RSP_ERR_DATA;
              rsp_err_q  <= 1'b1;
            end else begin
              wdata_q <= cmd_data_i;
            end
          end else if (tmo_done) begin
            tmo_cnt    <= '0;
            rsp_data_q <= RSP_ERR_DATA;
            rsp_err_q  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          rsp_data_q <= wdata_q;
          rsp_err_q  <= 1'b0;
        end
        ST_READ: begin
          rsp_data_q <= rd_word;
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready_o   = rst_n_i && ((state == ST_IDLE) || (state == ST_WDATA));
    rsp_valid_o   = (state == ST_RESP);
    rsp_data_o    = rsp_data_q;
    rsp_err_o     = rsp_err_q;
    reg_wr_data_o = wdata_q;
    stats_read_o  = (state == ST_READ) && (addr_q == StatsAddr);
    dec_state     = state;
    for (int i = 0; i < NumRegs; i++) begin
      reg_we_o[i] = (state == ST_WRITE) && (addr_q == 4'(i));
    end
  end

endmodule
